// File: rtl/exec_rsv_station_compact_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : rsv_pkg                                                        |
// | Purpose : Entry record and CDB wakeup helper shared by the reservation   |
// |           station, its interface and its testbench.                      |
// | Contents: RSV_TAG_W / RSV_DATA_W / RSV_PAYLOAD_W field widths,           |
// |           rsv_entry_t, rsv_wakeup().                                     |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package rsv_pkg;

  // Field widths of the stored entry; the station's width parameters default
  // to these and must be left equal to them.
  localparam int RSV_TAG_W     = 6;
  localparam int RSV_DATA_W    = 32;
  localparam int RSV_PAYLOAD_W = 40;

  typedef struct packed {
    logic                     valid;
    logic                     s1_rdy;
    logic [RSV_TAG_W-1:0]     s1_tag;
    logic [RSV_DATA_W-1:0]    s1_data;
    logic                     s2_rdy;
    logic [RSV_TAG_W-1:0]     s2_tag;
    logic [RSV_DATA_W-1:0]    s2_data;
    logic [RSV_PAYLOAD_W-1:0] payload;
  } rsv_entry_t;

  // Capture a CDB broadcast into any waiting source of a valid entry. Sources
  // that are already ready, and empty entries, are left untouched.
  function automatic rsv_entry_t rsv_wakeup(
    input rsv_entry_t            entry,
    input logic                  cdb_valid,
    input logic [RSV_TAG_W-1:0]  cdb_tag,
    input logic [RSV_DATA_W-1:0] cdb_data
  );
    rsv_entry_t res;
    res = entry;
    if (cdb_valid && entry.valid && !entry.s1_rdy && (entry.s1_tag == cdb_tag)) begin
      res.s1_rdy  = 1'b1;
      res.s1_data = cdb_data;
    end
    if (cdb_valid && entry.valid && !entry.s2_rdy && (entry.s2_tag == cdb_tag)) begin
      res.s2_rdy  = 1'b1;
      res.s2_data = cdb_data;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exec_rsv_station_compact_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : exec_rsv_station_compact_if                                  |
// | Purpose   : Dispatch, CDB and issue buses of the reservation station.    |
// | Modports  : slave  - the station (consumes dispatch/CDB, drives issue)   |
// |             master - the surrounding pipeline / testbench                |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
interface exec_rsv_station_compact_if
  import rsv_pkg::*;
#(
  parameter int TAG_W     = RSV_TAG_W,
  parameter int DATA_W    = RSV_DATA_W,
  parameter int PAYLOAD_W = RSV_PAYLOAD_W
);
  // dispatch
  logic                 i_disp_valid;
  logic                 o_disp_ready;
  logic [PAYLOAD_W-1:0] i_disp_payload;
  logic                 i_disp_s1_rdy;
  logic [TAG_W-1:0]     i_disp_s1_tag;
  logic [DATA_W-1:0]    i_disp_s1_data;
  logic                 i_disp_s2_rdy;
  logic [TAG_W-1:0]     i_disp_s2_tag;
  logic [DATA_W-1:0]    i_disp_s2_data;
  // common data bus
  logic                 i_cdb_valid;
  logic [TAG_W-1:0]     i_cdb_tag;
  logic [DATA_W-1:0]    i_cdb_data;
  // issue
  logic                 o_issue_valid;
  logic                 i_issue_ready;
  logic [PAYLOAD_W-1:0] o_issue_payload;
  logic [DATA_W-1:0]    o_issue_s1_data;
  logic [DATA_W-1:0]    o_issue_s2_data;

  modport slave (
    input  i_disp_valid, i_disp_payload,
           i_disp_s1_rdy, i_disp_s1_tag, i_disp_s1_data,
           i_disp_s2_rdy, i_disp_s2_tag, i_disp_s2_data,
           i_cdb_valid, i_cdb_tag, i_cdb_data, i_issue_ready,
    output o_disp_ready, o_issue_valid, o_issue_payload,
           o_issue_s1_data, o_issue_s2_data
  );

  modport master (
    output i_disp_valid, i_disp_payload,
           i_disp_s1_rdy, i_disp_s1_tag, i_disp_s1_data,
           i_disp_s2_rdy, i_disp_s2_tag, i_disp_s2_data,
           i_cdb_valid, i_cdb_tag, i_cdb_data, i_issue_ready,
    input  o_disp_ready, o_issue_valid, o_issue_payload,
           o_issue_s1_data, o_issue_s2_data
  );
endinterface
`default_nettype wire

// File: rtl/exec_rsv_station_compact_age_select.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : rsv_age_select                                                 |
// | Purpose : Priority encoder; grants the lowest-index (oldest) request.    |
// | Ports   : req   in  DEPTH  per-slot ready request                        |
// |           grant out DEPTH  one-hot grant (all zero when no request)      |
// |           idx   out IDX_W  index of the granted slot (0 when none)       |
// |           any   out 1      at least one request present                  |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module rsv_age_select #(
  parameter int DEPTH = 4,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  wire logic [DEPTH-1:0] req,
  output logic      [DEPTH-1:0] grant,
  output logic      [IDX_W-1:0] idx,
  output logic                  any
);
  // Walk from the youngest slot down so the oldest request is written last.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
        any      = 1'b1;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/exec_rsv_station_compact.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : exec_rsv_station_compact                                       |
// | Purpose : Age-ordered compacting reservation station for one FU. Slot 0  |
// |           is always the oldest entry; issuing an entry shifts all        |
// |           younger entries down one slot in the same cycle.               |
// | Ports   : i_clk    clock, rising edge                                    |
// |           i_rst_n  asynchronous reset, active-low                        |
// |           i_flush  synchronous squash of every entry                     |
// |           bus      dispatch / CDB / issue buses (slave side)             |
// |           o_count  occupied entries; o_empty / o_full status             |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module exec_rsv_station_compact
  import rsv_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int TAG_W     = RSV_TAG_W,
  parameter int DATA_W    = RSV_DATA_W,
  parameter int PAYLOAD_W = RSV_PAYLOAD_W
) (
  input  wire logic                       i_clk,
  input  wire logic                       i_rst_n,
  input  wire logic                       i_flush,
  exec_rsv_station_compact_if.slave       bus,
  output logic [$clog2(DEPTH+1)-1:0]      o_count,
  output logic                            o_empty,
  output logic                            o_full
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  rsv_entry_t             r_entries [DEPTH];
  logic       [CNT_W-1:0] r_count;

  rsv_entry_t             w_above   [DEPTH];
  rsv_entry_t             w_next    [DEPTH];
  rsv_entry_t             w_disp_raw;
  rsv_entry_t             w_disp_entry;
  logic       [DEPTH-1:0] w_req;
  logic       [DEPTH-1:0] w_grant;
  logic       [IDX_W-1:0] w_sel_idx;
  logic                   w_any;
  logic                   w_issue_valid;
  logic                   w_fire;
  logic                   w_accept;
  logic       [CNT_W-1:0] w_wr_idx;
  logic [PAYLOAD_W-1:0]   w_pay;
  logic [DATA_W-1:0]      w_s1;
  logic [DATA_W-1:0]      w_s2;

  // Per-slot ready requests and the entry that would shift into each slot.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    assign w_req[g] = r_entries[g].valid & r_entries[g].s1_rdy & r_entries[g].s2_rdy;
    if (g == DEPTH - 1) begin : g_top
      assign w_above[g] = '0;
    end else begin : g_mid
      assign w_above[g] = r_entries[g+1];
    end
  end

  rsv_age_select #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_age_select (
    .req   (w_req),
    .grant (w_grant),
    .idx   (w_sel_idx),
    .any   (w_any)
  );

  assign o_full        = (r_count == CNT_W'(DEPTH));
  assign o_empty       = (r_count == '0);
  assign o_count       = r_count;
  assign w_issue_valid = w_any & ~i_flush;
  assign w_fire        = w_issue_valid & bus.i_issue_ready;
  assign w_accept      = bus.i_disp_valid & ~o_full;
  // A same-cycle issue frees one slot below the tail, so the new entry lands one lower.
  assign w_wr_idx      = w_fire ? (r_count - CNT_W'(1)) : r_count;

  // Incoming entry, with CDB bypass for a source produced this very cycle.
  always_comb begin
    w_disp_raw         = '0;
    w_disp_raw.valid   = 1'b1;
    w_disp_raw.s1_rdy  = bus.i_disp_s1_rdy;
    w_disp_raw.s1_tag  = bus.i_disp_s1_tag;
    w_disp_raw.s1_data = bus.i_disp_s1_data;
    w_disp_raw.s2_rdy  = bus.i_disp_s2_rdy;
    w_disp_raw.s2_tag  = bus.i_disp_s2_tag;
    w_disp_raw.s2_data = bus.i_disp_s2_data;
    w_disp_raw.payload = bus.i_disp_payload;
    w_disp_entry = rsv_wakeup(w_disp_raw, bus.i_cdb_valid, bus.i_cdb_tag, bus.i_cdb_data);
  end

  // Slot next-state: shift (if at/above the issuing slot), then wakeup on the
  // shifted copy so a moving entry still sees this cycle's CDB, then dispatch.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_next[i] = (w_fire && (i >= int'(w_sel_idx))) ? w_above[i] : r_entries[i];
      w_next[i] = rsv_wakeup(w_next[i], bus.i_cdb_valid, bus.i_cdb_tag, bus.i_cdb_data);
      if (w_accept && (CNT_W'(i) == w_wr_idx)) begin
        w_next[i] = w_disp_entry;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) r_entries[i] <= w_next[i];
      r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_fire);
    end
  end

  // One-hot AND-OR output mux; everything reads zero when nothing is presented.
  always_comb begin
    w_pay = '0;
    w_s1  = '0;
    w_s2  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_grant[i] && w_issue_valid) begin
        w_pay = w_pay | r_entries[i].payload;
        w_s1  = w_s1  | r_entries[i].s1_data;
        w_s2  = w_s2  | r_entries[i].s2_data;
      end
    end
  end

  assign bus.o_disp_ready    = ~o_full;
  assign bus.o_issue_valid   = w_issue_valid;
  assign bus.o_issue_payload = w_pay;
  assign bus.o_issue_s1_data = w_s1;
  assign bus.o_issue_s2_data = w_s2;

  // Occupancy can never leave 0..DEPTH.
  always @(posedge i_clk) begin
    if (i_rst_n && !i_flush) begin
      assert (!(w_fire && (r_count == '0)));
      assert (!(w_accept && !w_fire && (r_count == CNT_W'(DEPTH))));
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_exec_rsv_station_compact.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_exec_rsv_station_compact                                    |
// | Purpose : Directed self-checking bench for exec_rsv_station_compact.     |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_exec_rsv_station_compact;
  import rsv_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [2:0] count;
  logic       empty;
  logic       full;
  int         passed;
  int         total;

  exec_rsv_station_compact_if bus ();

  exec_rsv_station_compact #(
    .DEPTH (4)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (flush),
    .bus     (bus),
    .o_count (count),
    .o_empty (empty),
    .o_full  (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [39:0] pl,
                      input logic s1r, input logic [5:0] s1t, input logic [31:0] s1d,
                      input logic s2r, input logic [5:0] s2t, input logic [31:0] s2d);
    bus.i_disp_valid   = 1'b1;
    bus.i_disp_payload = pl;
    bus.i_disp_s1_rdy  = s1r;
    bus.i_disp_s1_tag  = s1t;
    bus.i_disp_s1_data = s1d;
    bus.i_disp_s2_rdy  = s2r;
    bus.i_disp_s2_tag  = s2t;
    bus.i_disp_s2_data = s2d;
  endtask

  task automatic nodisp();
    bus.i_disp_valid = 1'b0;
  endtask

  task automatic cdb(input logic [5:0] t, input logic [31:0] d);
    bus.i_cdb_valid = 1'b1;
    bus.i_cdb_tag   = t;
    bus.i_cdb_data  = d;
  endtask

  task automatic nocdb();
    bus.i_cdb_valid = 1'b0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    flush  = 1'b0;
    bus.i_issue_ready = 1'b0;
    disp(40'h0, 1'b0, 6'h0, 32'h0, 1'b0, 6'h0, 32'h0);
    nodisp();
    cdb(6'h0, 32'h0);
    nocdb();
    #2;
    // reset state
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_disp_ready", bus.o_disp_ready, 1);
    chk("rst_issue_valid", bus.o_issue_valid, 0);
    chk("rst_payload", bus.o_issue_payload, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // A: both sources ready, issues the cycle after dispatch
    bus.i_issue_ready = 1'b1;
    disp(40'hA, 1'b1, 6'h0, 32'd5, 1'b1, 6'h0, 32'd7);
    #1;
    chk("a_pre_valid", bus.o_issue_valid, 0);
    tick(); nodisp(); #1;
    chk("a_count1", count, 1);
    chk("a_valid", bus.o_issue_valid, 1);
    chk("a_payload", bus.o_issue_payload, 40'hA);
    chk("a_s1", bus.o_issue_s1_data, 5);
    chk("a_s2", bus.o_issue_s2_data, 7);
    tick(); #1;
    chk("a_count0", count, 0);
    chk("a_empty", empty, 1);
    chk("a_post_valid", bus.o_issue_valid, 0);

    // Fill with four waiting entries; slot 2 waits only on src1 tag 0x12
    bus.i_issue_ready = 1'b0;
    disp(40'h1, 1'b0, 6'h10, 32'h0, 1'b0, 6'h20, 32'h0); tick();
    disp(40'h2, 1'b0, 6'h11, 32'h0, 1'b0, 6'h21, 32'h0); tick();
    disp(40'h3, 1'b0, 6'h12, 32'h0, 1'b1, 6'h0, 32'h33); tick();
    disp(40'h4, 1'b0, 6'h13, 32'h0, 1'b0, 6'h23, 32'h0); tick();
    disp(40'h5, 1'b1, 6'h0, 32'h1, 1'b1, 6'h0, 32'h2); #1;
    chk("fill_full", full, 1);
    chk("fill_disp_ready", bus.o_disp_ready, 0);
    chk("fill_count", count, 4);
    chk("fill_valid", bus.o_issue_valid, 0);
    tick(); nodisp(); #1;
    chk("full_stall_count", count, 4);
    cdb(6'h12, 32'h99);
    bus.i_issue_ready = 1'b1;
    tick(); nocdb(); #1;
    chk("wake2_valid", bus.o_issue_valid, 1);
    chk("wake2_payload", bus.o_issue_payload, 40'h3);
    chk("wake2_s1", bus.o_issue_s1_data, 32'h99);
    chk("wake2_s2", bus.o_issue_s2_data, 32'h33);
    tick(); bus.i_issue_ready = 1'b0; #1;
    chk("wake2_count", count, 3);
    chk("wake2_none_ready", bus.o_issue_valid, 0);

    // Wake slot 0 (P1) then slot 1 (P2) while stalled: slot 0 stays presented
    cdb(6'h10, 32'h01); tick();
    cdb(6'h20, 32'h02); tick(); nocdb(); #1;
    chk("hold_payload0", bus.o_issue_payload, 40'h1);
    cdb(6'h11, 32'h03); tick();
    cdb(6'h21, 32'h04); tick(); nocdb(); tick(); #1;
    chk("hold_payload3", bus.o_issue_payload, 40'h1);
    chk("hold_s1", bus.o_issue_s1_data, 32'h01);
    chk("hold_s2", bus.o_issue_s2_data, 32'h02);
    bus.i_issue_ready = 1'b1;
    tick(); #1;
    chk("seq2_payload", bus.o_issue_payload, 40'h2);
    chk("seq2_s1", bus.o_issue_s1_data, 32'h03);
    chk("seq2_count", count, 2);
    tick(); bus.i_issue_ready = 1'b0; #1;
    chk("seq_count1", count, 1);
    chk("seq_p4_waiting", bus.o_issue_valid, 0);

    // Fire slot 0 + dispatch B (src2 tag 0x05) + CDB 0x05 in one edge
    cdb(6'h13, 32'h44); tick();
    cdb(6'h23, 32'h55); tick(); nocdb(); #1;
    chk("p4_payload", bus.o_issue_payload, 40'h4);
    chk("p4_s1", bus.o_issue_s1_data, 32'h44);
    bus.i_issue_ready = 1'b1;
    disp(40'hB, 1'b1, 6'h0, 32'h1, 1'b0, 6'h05, 32'h0);
    cdb(6'h05, 32'hDEAD);
    #1;
    chk("byp_disp_ready", bus.o_disp_ready, 1);
    tick(); nodisp(); nocdb(); bus.i_issue_ready = 1'b0; #1;
    chk("byp_count", count, 1);
    chk("byp_valid", bus.o_issue_valid, 1);
    chk("byp_payload", bus.o_issue_payload, 40'hB);
    chk("byp_s1", bus.o_issue_s1_data, 32'h1);
    chk("byp_s2", bus.o_issue_s2_data, 32'hDEAD);

    // Wake an entry on the same edge it shifts down
    disp(40'hC, 1'b0, 6'h30, 32'h0, 1'b0, 6'h31, 32'h0); tick();
    disp(40'hD, 1'b0, 6'h32, 32'h0, 1'b1, 6'h0, 32'h66); tick(); nodisp();
    bus.i_issue_ready = 1'b1;
    cdb(6'h32, 32'h77);
    #1;
    chk("shw_pre_payload", bus.o_issue_payload, 40'hB);
    chk("shw_pre_count", count, 3);
    tick(); nocdb(); bus.i_issue_ready = 1'b0; #1;
    chk("shw_count", count, 2);
    chk("shw_payload", bus.o_issue_payload, 40'hD);
    chk("shw_s1", bus.o_issue_s1_data, 32'h77);
    chk("shw_s2", bus.o_issue_s2_data, 32'h66);

    // Flush with 3 entries while an entry is presented
    disp(40'hE, 1'b0, 6'h3A, 32'h0, 1'b0, 6'h3B, 32'h0); tick(); nodisp(); #1;
    chk("fl_count3", count, 3);
    chk("fl_pre_valid", bus.o_issue_valid, 1);
    flush = 1'b1;
    bus.i_issue_ready = 1'b1;
    cdb(6'h30, 32'h1);
    disp(40'hF, 1'b1, 6'h0, 32'h9, 1'b1, 6'h0, 32'h9);
    #1;
    chk("fl_valid_now", bus.o_issue_valid, 0);
    chk("fl_payload_zero", bus.o_issue_payload, 0);
    tick(); flush = 1'b0; bus.i_issue_ready = 1'b0; nocdb(); #1;
    chk("fl_count0", count, 0);
    chk("fl_empty", empty, 1);
    chk("fl_disp_ready", bus.o_disp_ready, 1);
    disp(40'h10, 1'b0, 6'h3A, 32'h0, 1'b0, 6'h3A, 32'h0);
    tick(); nodisp(); #1;
    chk("fl_accept_count", count, 1);
    chk("fl_g_waiting", bus.o_issue_valid, 0);

    // One tag feeding both sources; later rebroadcast of that tag is ignored
    cdb(6'h3A, 32'h88); tick();
    cdb(6'h3A, 32'h99); #1;
    chk("both_valid", bus.o_issue_valid, 1);
    chk("both_s1", bus.o_issue_s1_data, 32'h88);
    chk("both_s2", bus.o_issue_s2_data, 32'h88);
    tick(); nocdb(); #1;
    chk("rdy_ignore_s1", bus.o_issue_s1_data, 32'h88);
    chk("rdy_ignore_s2", bus.o_issue_s2_data, 32'h88);
    bus.i_issue_ready = 1'b1;
    tick(); bus.i_issue_ready = 1'b0; #1;
    chk("end_count", count, 0);
    chk("end_empty", empty, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire
